spi_flash_arbiter: RTL

Shares the single SPI flash read engine between two requesters: the 6809 CPU read path (port 0) and the boot/shadow-copy DMA (port 1). Round-robin arbitration, one byte-read transaction at a time. Drives the engine over a start/done handshake, returns the byte to the granted requester, generates the CPU wait-state signal, and times out hung transactions. Sits between the address decoder / DMA and the SPI flash byte-read engine.

---
 rtl/spi_flash_arb_pkg.sv | 23 ++
 rtl/rr_arbiter_2.sv | 39 +++
 rtl/spi_flash_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/spi_flash_arb_pkg.sv
// Shared types and constants for the SPI flash read arbiter.
package spi_flash_arb_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 8;

  // Requester port indices; also the encoding of the grant/last_grant bits.
  localparam bit PORT_CPU = 1'b0;
  localparam bit PORT_DMA = 1'b1;

  // Watchdog limit in cycles from engine start to engine done.
  localparam int TIMEOUT_DEF = 4096;
  // Byte handed back to the requester when the engine never answers.
  localparam logic [DATA_W-1:0] FILL_BYTE_DEF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    ACK       = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-request round-robin arbiter. The grant is combinational from the
// request vector and the remembered last grant; the owner pulses update
// once a transaction has been served so fairness advances per completion,
// not per request.
module rr_arbiter_2
  import spi_flash_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       upd_port,
  output logic       gnt_valid,
  output logic       gnt_port
);

  logic last_grant;

  // Remember who was served last; reset favours the CPU on the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= PORT_DMA;
    end else if (update) begin
      last_grant <= upd_port;
    end
  end

  // Single request wins outright; on a tie the port not served last wins.
  always_comb begin
    gnt_valid = |req;
    gnt_port  = PORT_CPU;
    if (req == 2'b11) begin
      gnt_port = ~last_grant;
    end else if (req[1]) begin
      gnt_port = PORT_DMA;
    end
  end

endmodule

// File: rtl/spi_flash_arbiter.sv
// Shares the SPI flash byte-read engine between the 6809 CPU read path
// and the boot/shadow-copy DMA, one byte transaction at a time.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | no transaction; arbitrate and latch the winner's address
// START     | wait for the engine to go idle, then pulse o_ENG_START
// WAIT_DONE | wait for i_ENG_DONE or the watchdog to expire
// ACK       | one-cycle ACK to the granted port, advance round-robin
module spi_flash_arbiter
  import spi_flash_arb_pkg::*;
#(
  parameter int                TIMEOUT   = TIMEOUT_DEF,
  parameter logic [DATA_W-1:0] FILL_BYTE = FILL_BYTE_DEF
) (
  input  logic              clk,
  input  logic              i_RESET_N,
  input  logic              i_CPU_REQ,
  input  logic [ADDR_W-1:0] i_CPU_ADDR,
  output logic [DATA_W-1:0] o_CPU_DATA,
  output logic              o_CPU_ACK,
  output logic              o_CPU_READY,
  input  logic              i_DMA_REQ,
  input  logic [ADDR_W-1:0] i_DMA_ADDR,
  output logic [DATA_W-1:0] o_DMA_DATA,
  output logic              o_DMA_ACK,
  output logic              o_ENG_START,
  output logic [ADDR_W-1:0] o_ENG_ADDR,
  input  logic              i_ENG_BUSY,
  input  logic              i_ENG_DONE,
  input  logic [DATA_W-1:0] i_ENG_DATA,
  output logic              o_TIMEOUT
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t        state, state_nxt;
  logic              gnt_valid, gnt_port;
  logic              grant_port;
  logic              cpu_served;
  logic [CNT_W-1:0]  wd_cnt;
  logic              grant_load, start_fire, done_take, tmo_take, arb_update;
  logic [DATA_W-1:0] rd_byte;

  rr_arbiter_2 u_rr (
    .clk       (clk),
    .rst_n     (i_RESET_N),
    .req       ({i_DMA_REQ, i_CPU_REQ}),
    .update    (arb_update),
    .upd_port  (grant_port),
    .gnt_valid (gnt_valid),
    .gnt_port  (gnt_port)
  );

  // The CPU is held in wait states from its request until its own ACK.
  assign o_CPU_READY = ~(i_CPU_REQ & ~cpu_served);

  // A real engine byte always beats the watchdog in the same cycle.
  assign rd_byte = done_take ? i_ENG_DATA : FILL_BYTE;

  // State register.
  always_ff @(posedge clk or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and single-cycle control strobes.
  always_comb begin
    state_nxt  = state;
    grant_load = 1'b0;
    start_fire = 1'b0;
    done_take  = 1'b0;
    tmo_take   = 1'b0;
    arb_update = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          grant_load = 1'b1;
          state_nxt  = START;
        end
      end
      START: begin
        if (!i_ENG_BUSY) begin
          start_fire = 1'b1;
          state_nxt  = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (i_ENG_DONE) begin
          done_take = 1'b1;
          state_nxt = ACK;
        end else if (wd_cnt == CNT_LAST) begin
          tmo_take  = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        arb_update = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant/address latch, engine start pulse, return data and ACK pulses.
  always_ff @(posedge clk or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      grant_port  <= PORT_CPU;
      o_ENG_ADDR  <= '0;
      o_ENG_START <= 1'b0;
      o_CPU_DATA  <= '0;
      o_DMA_DATA  <= '0;
      o_CPU_ACK   <= 1'b0;
      o_DMA_ACK   <= 1'b0;
      o_TIMEOUT   <= 1'b0;
    end else begin
      o_ENG_START <= start_fire;
      o_CPU_ACK   <= (done_take | tmo_take) & (grant_port == PORT_CPU);
      o_DMA_ACK   <= (done_take | tmo_take) & (grant_port == PORT_DMA);
      if (grant_load) begin
        grant_port <= gnt_port;
        o_ENG_ADDR <= (gnt_port == PORT_DMA) ? i_DMA_ADDR : i_CPU_ADDR;
      end
      if (done_take | tmo_take) begin
        if (grant_port == PORT_CPU) begin
          o_CPU_DATA <= rd_byte;
        end else begin
          o_DMA_DATA <= rd_byte;
        end
      end
      if (tmo_take) begin
        o_TIMEOUT <= 1'b1;
      end
    end
  end

  // Watchdog: holds at zero through the start-pulse cycle so the limit
  // counts whole cycles after the start, then saturates.
  always_ff @(posedge clk or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      wd_cnt <= '0;
    end else if (start_fire) begin
      wd_cnt <= '0;
    end else if (state == WAIT_DONE && !o_ENG_START && wd_cnt != '1) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Remember that the current CPU request has been answered until it drops.
  always_ff @(posedge clk or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      cpu_served <= 1'b0;
    end else if ((done_take | tmo_take) && grant_port == PORT_CPU) begin
      cpu_served <= 1'b1;
    end else if (!i_CPU_REQ) begin
      cpu_served <= 1'b0;
    end
  end

endmodule
